gl_frac_deriv: RTL and testbench

//  Parametrised Grunwald-Letnikov fractional-order derivative engine:
//  y(n) = H_INV_A * sum_{k=0..DEPTH-1} w_k * x(n-k), in signed fixed point.

---
 rtl/gl_frac_pkg.sv | 36 +++
 rtl/gl_hist_ram.sv | 55 +++++
 rtl/gl_frac_deriv.sv | 156 +++++++++++++++
 tb/tb_gl_frac_deriv.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gl_frac_pkg.sv
`default_nettype none
// ============================================================================
// Package  : gl_frac_pkg
// Purpose  : Shared types and helpers for the Grunwald-Letnikov derivative.
// Revision : 1.0  initial release
// ============================================================================
package gl_frac_pkg;

    localparam int MAX_W      = 128;
    localparam int FRAC_W_DEF = 24;
    localparam logic [63:0] ONE_Q = 64'd1 << FRAC_W_DEF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MAC   = 2'd1,
        SCALE = 2'd2
    } state_t;

    function automatic int acc_w(input int data_w, input int aw);
        return 2 * data_w + aw;
    endfunction

    // Returns 2'b01 when v overflows data_w positively, 2'b10 negatively.
    function automatic logic [1:0] saturate(input logic signed [MAX_W-1:0] v,
                                            input int data_w);
        logic signed [MAX_W-1:0] hi;
        logic signed [MAX_W-1:0] lo;
        hi = $signed((MAX_W'(1) << (data_w - 1)) - MAX_W'(1));
        lo = ~hi;
        if (v > hi)      return 2'b01;
        else if (v < lo) return 2'b10;
        else             return 2'b00;
    endfunction

endpackage
`default_nettype wire

// File: rtl/gl_hist_ram.sv
`default_nettype none
// ============================================================================
// Module   : gl_hist_ram
// Purpose  : Circular sample history with fill count; tap k reads x(n-k).
// Revision : 1.0  initial release
// ============================================================================
module gl_hist_ram #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16,
    localparam int AW    = $clog2(DEPTH),
    localparam int FW    = $clog2(DEPTH + 1)
) (
    input  logic              clk_100HZ,
    input  logic              Rst_n,
    input  logic              i_clr,
    input  logic              i_we,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [AW-1:0]     i_rd_k,
    output logic [DATA_W-1:0] o_rd_data,
    output logic [FW-1:0]     o_fill
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wptr;
    logic [FW-1:0]     r_fill;
    logic [AW:0]       w_idx_raw;
    logic [AW-1:0]     w_idx;

    always_ff @(posedge clk_100HZ or negedge Rst_n) begin
        if (!Rst_n) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_wptr <= '0;
            r_fill <= '0;
        end else if (i_clr) begin
            r_wptr <= '0;
            r_fill <= '0;
        end else if (i_we) begin
            r_mem[r_wptr] <= i_wdata;
            r_wptr        <= (r_wptr == AW'(DEPTH - 1)) ? '0 : r_wptr + 1'b1;
            if (r_fill != FW'(DEPTH)) r_fill <= r_fill + 1'b1;
        end
    end

    // Pointer already advanced past the newest sample: (wptr-1-k) mod DEPTH.
    always_comb begin
        w_idx_raw = {1'b0, r_wptr} + (AW+1)'(DEPTH - 1) - {1'b0, i_rd_k};
        w_idx     = AW'((w_idx_raw >= (AW+1)'(DEPTH)) ? w_idx_raw - (AW+1)'(DEPTH)
                                                       : w_idx_raw);
    end

    assign o_rd_data = r_mem[w_idx];
    assign o_fill    = r_fill;

endmodule
`default_nettype wire

// File: rtl/gl_frac_deriv.sv
`default_nettype none
// ============================================================================
// Module   : gl_frac_deriv
// Purpose  : Grunwald-Letnikov fractional derivative, one MAC per clock.
// Revision : 1.0  initial release
// ============================================================================
module gl_frac_deriv
    import gl_frac_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int FRAC_W = 24,
    parameter int DEPTH  = 16,
    parameter logic signed [DATA_W-1:0] H_INV_A = DATA_W'(64'd100 << FRAC_W),
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              clk_100HZ,
    input  logic              Rst_n,
    input  logic [DATA_W-1:0] Signal_i,
    input  logic              Valid_i,
    output logic              Ready_o,
    input  logic              Clear_i,
    input  logic              Coef_we_i,
    input  logic [AW-1:0]     Coef_addr_i,
    input  logic [DATA_W-1:0] Coef_data_i,
    output logic              Coef_err_o,
    output logic [DATA_W-1:0] Output_o,
    output logic              Out_valid_o,
    output logic              OutInd_o,
    output logic              Sat_o
);

    localparam int FW    = $clog2(DEPTH + 1);
    localparam int ACC_W = acc_w(DATA_W, AW);
    localparam int SW    = ACC_W + DATA_W;

    localparam logic signed [DATA_W-1:0] c_one_q    = DATA_W'(1) << FRAC_W;
    localparam logic signed [DATA_W-1:0] c_max      = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic signed [DATA_W-1:0] c_min      = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic signed [ACC_W-1:0]  c_half_acc = ACC_W'(1) << (FRAC_W - 1);
    localparam logic signed [SW-1:0]     c_half_sw  = SW'(1) << (FRAC_W - 1);
    localparam logic signed [SW-1:0]     c_h_ext    = SW'(H_INV_A);

    state_t                     r_state, w_state_nxt;
    logic signed [DATA_W-1:0]   r_coef [DEPTH];
    logic [AW-1:0]              r_k;
    logic signed [ACC_W-1:0]    r_acc;
    logic [DATA_W-1:0]          r_out;
    logic                       r_out_valid, r_out_ind, r_sat, r_coef_err, r_clr_pend;

    logic                       w_accept, w_hist_clr, w_mac_last;
    logic signed [DATA_W-1:0]   w_tap;
    logic [FW-1:0]              w_fill;
    logic signed [2*DATA_W-1:0] w_prod;
    logic signed [ACC_W-1:0]    w_term, w_r;
    logic signed [SW-1:0]       w_r_ext, w_scaled;
    logic [1:0]                 w_sat_code;
    logic signed [DATA_W-1:0]   w_y;

    // A clear in IDLE wins over a simultaneous accept; a clear raised while
    // busy is held and applied as the result retires.
    assign w_accept   = (r_state == IDLE) && Valid_i && !Clear_i;
    assign w_hist_clr = ((r_state == IDLE) && Clear_i) ||
                        ((r_state == SCALE) && (r_clr_pend || Clear_i));
    assign w_mac_last = (r_k == AW'(DEPTH - 1));

    gl_hist_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_hist (
        .clk_100HZ (clk_100HZ),
        .Rst_n     (Rst_n),
        .i_clr     (w_hist_clr),
        .i_we      (w_accept),
        .i_wdata   (Signal_i),
        .i_rd_k    (r_k),
        .o_rd_data (w_tap),
        .o_fill    (w_fill)
    );

    always_ff @(posedge clk_100HZ or negedge Rst_n) begin
        if (!Rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_state_nxt = MAC;
            MAC:     if (w_mac_last) w_state_nxt = SCALE;
            SCALE:   w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_prod = r_coef[r_k] * w_tap;
        w_term = '0;
        if (FW'(r_k) < w_fill) w_term = ACC_W'(w_prod);
        w_r        = (r_acc + c_half_acc) >>> FRAC_W;
        w_r_ext    = SW'(w_r);
        w_scaled   = (w_r_ext * c_h_ext + c_half_sw) >>> FRAC_W;
        w_sat_code = saturate(MAX_W'(w_scaled), DATA_W);
        case (w_sat_code)
            2'b01:   w_y = c_max;
            2'b10:   w_y = c_min;
            default: w_y = w_scaled[DATA_W-1:0];
        endcase
    end

    always_ff @(posedge clk_100HZ or negedge Rst_n) begin
        if (!Rst_n) begin
            for (int i = 0; i < DEPTH; i++) r_coef[i] <= '0;
            r_coef[0]   <= c_one_q;
            r_k         <= '0;
            r_acc       <= '0;
            r_out       <= '0;
            r_out_valid <= 1'b0;
            r_out_ind   <= 1'b0;
            r_sat       <= 1'b0;
            r_coef_err  <= 1'b0;
            r_clr_pend  <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            r_coef_err  <= Coef_we_i && (r_state != IDLE);
            if (Coef_we_i && (r_state == IDLE)) r_coef[Coef_addr_i] <= Coef_data_i;
            if (r_state == SCALE)                    r_clr_pend <= 1'b0;
            else if ((r_state != IDLE) && Clear_i)   r_clr_pend <= 1'b1;
            case (r_state)
                IDLE: if (w_accept) begin
                    r_acc <= '0;
                    r_k   <= '0;
                end
                MAC: begin
                    r_acc <= r_acc + w_term;
                    r_k   <= r_k + 1'b1;
                end
                SCALE: begin
                    r_out       <= w_y;
                    r_sat       <= (w_sat_code != 2'b00);
                    r_out_valid <= 1'b1;
                    r_out_ind   <= ~r_out_ind;
                end
                default: ;
            endcase
        end
    end

    assign Ready_o     = (r_state == IDLE);
    assign Coef_err_o  = r_coef_err;
    assign Output_o    = r_out;
    assign Out_valid_o = r_out_valid;
    assign OutInd_o    = r_out_ind;
    assign Sat_o       = r_sat;

endmodule
`default_nettype wire

// File: tb/tb_gl_frac_deriv.sv
`default_nettype none
// ============================================================================
// Module   : tb_gl_frac_deriv
// Purpose  : Self-checking bench for gl_frac_deriv against an arithmetic model.
// Revision : 1.0  initial release
// ============================================================================
module tb_gl_frac_deriv;

    localparam int DEPTH = 4;
    localparam logic signed [31:0] ONE   = 32'sh0100_0000;
    localparam logic signed [31:0] H_VAL = 32'sh6400_0000;

    logic        clk_100HZ = 1'b0;
    logic        Rst_n     = 1'b0;
    logic [31:0] Signal_i  = '0;
    logic        Valid_i   = 1'b0;
    logic        Ready_o;
    logic        Clear_i   = 1'b0;
    logic        Coef_we_i = 1'b0;
    logic [1:0]  Coef_addr_i = '0;
    logic [31:0] Coef_data_i = '0;
    logic        Coef_err_o;
    logic [31:0] Output_o;
    logic        Out_valid_o;
    logic        OutInd_o;
    logic        Sat_o;

    int checks = 0;
    int errors = 0;

    logic signed [31:0] m_coef [DEPTH];
    logic signed [31:0] m_hist [$];
    logic               m_ind;

    always #5 clk_100HZ = ~clk_100HZ;

    gl_frac_deriv #(
        .DATA_W  (32),
        .FRAC_W  (24),
        .DEPTH   (DEPTH),
        .H_INV_A (H_VAL)
    ) dut (
        .clk_100HZ   (clk_100HZ),
        .Rst_n       (Rst_n),
        .Signal_i    (Signal_i),
        .Valid_i     (Valid_i),
        .Ready_o     (Ready_o),
        .Clear_i     (Clear_i),
        .Coef_we_i   (Coef_we_i),
        .Coef_addr_i (Coef_addr_i),
        .Coef_data_i (Coef_data_i),
        .Coef_err_o  (Coef_err_o),
        .Output_o    (Output_o),
        .Out_valid_o (Out_valid_o),
        .OutInd_o    (OutInd_o),
        .Sat_o       (Sat_o)
    );

    task automatic tick();
        @(posedge clk_100HZ);
        #1;
    endtask

    function automatic logic signed [31:0] rnd(input int mag);
        int v;
        v = int'($urandom_range(0, 2 * mag));
        return 32'(v - mag);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) m_coef[i] = '0;
        m_coef[0] = ONE;
        m_hist.delete();
        m_ind = 1'b0;
    endtask

    // y = H * sum(w_k * x(n-k)) with the two rounding steps, then clamp.
    function automatic void model_eval(output logic [31:0] y, output logic s);
        logic signed [127:0] acc, r, p;
        acc = '0;
        for (int k = 0; k < m_hist.size(); k++)
            acc += 128'(m_coef[k]) * 128'(m_hist[k]);
        r = (acc + 128'sd8388608) >>> 24;
        p = (r * 128'(H_VAL) + 128'sd8388608) >>> 24;
        if (p > 128'sd2147483647) begin
            y = 32'h7FFF_FFFF; s = 1'b1;
        end else if (p < -128'sd2147483648) begin
            y = 32'h8000_0000; s = 1'b1;
        end else begin
            y = p[31:0]; s = 1'b0;
        end
    endfunction

    task automatic apply_reset();
        Rst_n = 1'b0; Valid_i = 1'b0; Clear_i = 1'b0; Coef_we_i = 1'b0;
        repeat (3) tick();
        Rst_n = 1'b1;
        model_reset();
        tick();
    endtask

    task automatic write_coef(input int k, input logic signed [31:0] v);
        Coef_we_i = 1'b1; Coef_addr_i = 2'(k); Coef_data_i = v;
        tick();
        Coef_we_i = 1'b0;
        m_coef[k] = v;
    endtask

    // Accepts one sample (optionally with a same-cycle coefficient write) and
    // waits for the result; lat=99 marks a missing Out_valid_o.
    task automatic send_sample(input logic signed [31:0] x, input logic cw,
                               input int ck, input logic signed [31:0] cv,
                               output logic [31:0] y, output logic s,
                               output int lat, output int busy);
        Signal_i = x; Valid_i = 1'b1;
        Coef_we_i = cw; Coef_addr_i = 2'(ck); Coef_data_i = cv;
        tick();
        Valid_i = 1'b0; Coef_we_i = 1'b0;
        if (cw) m_coef[ck] = cv;
        m_hist.push_front(x);
        if (m_hist.size() > DEPTH) void'(m_hist.pop_back());
        lat = 99;
        busy = (Ready_o == 1'b0) ? 1 : 0;
        for (int n = 1; n <= 20; n++) begin
            tick();
            if (Out_valid_o) begin
                lat = n;
                break;
            end
            if (!Ready_o) busy++;
        end
        y = Output_o; s = Sat_o;
        m_ind = ~m_ind;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if ({Ready_o, Out_valid_o, OutInd_o, Sat_o, Coef_err_o} !== 5'b10000) begin
            errors++;
            $display("FAIL reset_flags got %b exp 10000",
                     {Ready_o, Out_valid_o, OutInd_o, Sat_o, Coef_err_o});
        end
        checks++;
        if (Output_o !== 32'd0) begin
            errors++; $display("FAIL reset_output got %h exp 0", Output_o);
        end
    endtask

    task automatic test_default();
        logic [31:0] y, ey; logic s, es; int lat, busy;
        send_sample(ONE, 1'b0, 0, '0, y, s, lat, busy);
        model_eval(ey, es);
        checks++;
        if (y !== 32'd1677721600) begin
            errors++; $display("FAIL default_y got %0d exp 1677721600", y);
        end
        checks++;
        if (y !== ey) begin
            errors++; $display("FAIL default_model got %0d exp %0d", y, ey);
        end
        checks++;
        if (lat !== 5) begin
            errors++; $display("FAIL default_latency got %0d exp 5", lat);
        end
        checks++;
        if (busy !== 5) begin
            errors++; $display("FAIL default_ready_low got %0d exp 5", busy);
        end
        checks++;
        if (OutInd_o !== m_ind || m_ind !== 1'b1) begin
            errors++; $display("FAIL default_outind got %b exp 1", OutInd_o);
        end
    endtask

    task automatic test_difference();
        logic [31:0] y, ey; logic s, es; int lat, busy;
        apply_reset();
        write_coef(1, -ONE);
        send_sample(ONE, 1'b0, 0, '0, y, s, lat, busy);
        checks++;
        if (y !== 32'd1677721600) begin
            errors++; $display("FAIL diff_first got %0d exp 1677721600", y);
        end
        send_sample(32'sd16944988, 1'b0, 0, '0, y, s, lat, busy);
        model_eval(ey, es);
        checks++;
        if (y !== ey || $signed(y) - ONE > 1024 || ONE - $signed(y) > 1024) begin
            errors++; $display("FAIL diff_second got %0d exp %0d", y, ey);
        end
    endtask

    task automatic test_saturation();
        logic [31:0] y; logic s; int lat, busy;
        apply_reset();
        send_sample(32'sh7FFF_FFFF, 1'b0, 0, '0, y, s, lat, busy);
        checks++;
        if (y !== 32'h7FFF_FFFF || s !== 1'b1) begin
            errors++; $display("FAIL sat_pos got %h/%b exp 7fffffff/1", y, s);
        end
        send_sample(-32'sh7FFF_FFFF, 1'b0, 0, '0, y, s, lat, busy);
        checks++;
        if (y !== 32'h8000_0000 || s !== 1'b1) begin
            errors++; $display("FAIL sat_neg got %h/%b exp 80000000/1", y, s);
        end
        send_sample(32'sd0, 1'b0, 0, '0, y, s, lat, busy);
        checks++;
        if (y !== 32'd0 || s !== 1'b0) begin
            errors++; $display("FAIL sat_clear got %h/%b exp 0/0", y, s);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] y, ey; logic s, es; int lat, busy;
        apply_reset();
        write_coef(0, '0);
        write_coef(3, ONE);
        for (int i = 0; i < 6; i++) begin
            send_sample(rnd(1 << 24), 1'b0, 0, '0, y, s, lat, busy);
            model_eval(ey, es);
            checks++;
            if (y !== ey || s !== es || (i < 3 && y !== 32'd0)) begin
                errors++; $display("FAIL wrap_%0d got %0d/%b exp %0d/%b", i, y, s, ey, es);
            end
        end
    endtask

    task automatic test_err_and_clear();
        logic [31:0] y, ey; logic s, es; int lat, busy, seen;
        for (int k = 0; k < DEPTH; k++) write_coef(k, rnd(1 << 25));
        Signal_i = rnd(1 << 24); Valid_i = 1'b1;
        tick();
        Valid_i = 1'b0;
        m_hist.push_front(Signal_i);
        if (m_hist.size() > DEPTH) void'(m_hist.pop_back());
        model_eval(ey, es);
        Coef_we_i = 1'b1; Coef_addr_i = 2'd0; Coef_data_i = rnd(1 << 25); Clear_i = 1'b1;
        tick();
        Coef_we_i = 1'b0; Clear_i = 1'b0;
        checks++;
        if (Coef_err_o !== 1'b1) begin
            errors++; $display("FAIL coef_err_pulse got %b exp 1", Coef_err_o);
        end
        lat = 99;
        for (int n = 0; n < 20; n++) begin
            if (Out_valid_o) begin lat = n; break; end
            tick();
        end
        m_ind = ~m_ind;
        checks++;
        if (lat == 99 || Output_o !== ey) begin
            errors++; $display("FAIL busy_clear_result got %0d exp %0d", Output_o, ey);
        end
        m_hist.delete();
        Signal_i = rnd(1 << 24); Valid_i = 1'b1; Clear_i = 1'b1;
        tick();
        Valid_i = 1'b0; Clear_i = 1'b0;
        checks++;
        if (Ready_o !== 1'b1) begin
            errors++; $display("FAIL clear_priority_ready got %b exp 1", Ready_o);
        end
        seen = 0;
        repeat (8) begin
            tick();
            if (Out_valid_o) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++; $display("FAIL clear_no_output got %0d exp 0", seen);
        end
        send_sample(rnd(1 << 24), 1'b0, 0, '0, y, s, lat, busy);
        model_eval(ey, es);
        checks++;
        if (y !== ey || s !== es) begin
            errors++; $display("FAIL clear_empty_hist got %0d exp %0d", y, ey);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] y, ey; logic s, es; int lat, busy; logic cw;
        for (int i = 0; i < 10; i++) begin
            cw = ($urandom_range(0, 1) == 1);
            send_sample(rnd(1 << 25), cw, int'($urandom_range(0, DEPTH - 1)),
                        rnd(1 << 25), y, s, lat, busy);
            model_eval(ey, es);
            checks++;
            if (y !== ey || s !== es || OutInd_o !== m_ind || lat !== 5) begin
                errors++;
                $display("FAIL b2b_%0d got %0d/%b/%b/%0d exp %0d/%b/%b/5",
                         i, y, s, OutInd_o, lat, ey, es, m_ind);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] y; logic s; int lat, busy, seen;
        write_coef(0, rnd(1 << 23));
        Signal_i = ONE; Valid_i = 1'b1;
        tick();
        Valid_i = 1'b0;
        tick();
        Rst_n = 1'b0;
        #1;
        checks++;
        if (Ready_o !== 1'b1) begin
            errors++; $display("FAIL midreset_ready got %b exp 1", Ready_o);
        end
        seen = 0;
        repeat (8) begin
            tick();
            if (Out_valid_o) seen++;
        end
        Rst_n = 1'b1;
        model_reset();
        tick();
        checks++;
        if (seen !== 0 || Ready_o !== 1'b1 || Output_o !== 32'd0 || OutInd_o !== 1'b0) begin
            errors++;
            $display("FAIL midreset_state got ov=%0d rdy=%b out=%h ind=%b exp 0/1/0/0",
                     seen, Ready_o, Output_o, OutInd_o);
        end
        send_sample(ONE, 1'b0, 0, '0, y, s, lat, busy);
        checks++;
        if (y !== 32'd1677721600) begin
            errors++; $display("FAIL midreset_coef got %0d exp 1677721600", y);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_default();
        test_difference();
        test_saturation();
        test_wrap();
        test_err_and_clear();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
